// File: rtl/puf_pkg.sv
// Shared types and defaults for the delay-PUF challenge sequencer.
package puf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    localparam int PUF_LENGTH_DEF    = 8;
    localparam int RUN_CYCLES_DEF    = 10;
    localparam int SETTLE_CYCLES_DEF = 10;

    // Signature width for a given challenge width: one response bit per challenge.
    function automatic int sig_width(input int len);
        return 1 << len;
    endfunction

endpackage

// File: rtl/puf_phase_timer.sv
// Loadable down-counter shared by the RUN and SETTLE phases.
// Loading N-1 makes o_expire assert in the N-th cycle after the load.
module puf_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    // Load a new phase length, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Sweeps every challenge of the delay PUF, strobes run, samples the
// synchronized response into the signature and counts golden mismatches.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int  PUF_LENGTH    = PUF_LENGTH_DEF,
    parameter int  RUN_CYCLES    = RUN_CYCLES_DEF,
    parameter int  SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    localparam int SIG_W         = sig_width(PUF_LENGTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SIG_W-1:0]      golden,
    output logic [PUF_LENGTH-1:0] puf_challenge,
    output logic                  puf_run,
    input  logic                  puf_result,
    output logic                  busy,
    output logic                  done,
    output logic [SIG_W-1:0]      signature,
    output logic [PUF_LENGTH:0]   err_count,
    output logic                  match
);

    localparam int MAX_CYC = (RUN_CYCLES > SETTLE_CYCLES) ? RUN_CYCLES : SETTLE_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0]         RUN_LOAD    = TW'(RUN_CYCLES - 1);
    localparam logic [TW-1:0]         SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [PUF_LENGTH-1:0] LAST_IDX    = PUF_LENGTH'(SIG_W - 1);

    seq_state_t            r_state;
    logic [PUF_LENGTH-1:0] r_index;
    logic                  r_run;
    logic                  r_busy;
    logic                  r_done;
    logic [SIG_W-1:0]      r_signature;
    logic [PUF_LENGTH:0]   r_err_count;

    logic                  w_expire;
    logic                  w_load;
    logic [TW-1:0]         w_load_val;
    logic                  w_last;
    logic                  w_mismatch;

    assign w_last     = (r_index == LAST_IDX);
    assign w_mismatch = puf_result ^ golden[r_index];

    puf_phase_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    // Reload the phase timer on every transition into RUN or SETTLE.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = RUN_LOAD;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load     = 1'b1;
                    w_load_val = RUN_LOAD;
                end
            end
            RUN: begin
                if (w_expire) begin
                    w_load     = 1'b1;
                    w_load_val = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (w_expire && !w_last) begin
                    w_load     = 1'b1;
                    w_load_val = RUN_LOAD;
                end
            end
            default: ;
        endcase
    end

    // Sweep FSM with registered strobes, signature shifter and mismatch counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_index     <= '0;
            r_run       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_signature <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_index     <= '0;
                        r_err_count <= '0;
                        r_run       <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    if (w_expire) begin
                        r_run   <= 1'b0;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_expire) begin
                        // Right shift so challenge 0 ends up in bit 0 after the full sweep.
                        r_signature <= {puf_result, r_signature[SIG_W-1:1]};
                        r_err_count <= r_err_count + {{PUF_LENGTH{1'b0}}, w_mismatch};
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_index <= r_index + PUF_LENGTH'(1);
                            r_run   <= 1'b1;
                            r_state <= RUN;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign puf_challenge = r_index;
    assign puf_run       = r_run;
    assign busy          = r_busy;
    assign done          = r_done;
    assign signature     = r_signature;
    assign err_count     = r_err_count;
    assign match         = (r_err_count == '0);

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Synthesizable initiator for the delay PUF: sweeps the full challenge space, pulses `run` per challenge, samples the synchronized `result` and assembles the 2^PUF_LENGTH-bit device signature. It also counts bit mismatches against a supplied golden signature. It sits between the PUF core and the host/enrolment logic, so characterization does not need a simulator-side sweep.

## Interface
- `PUF_LENGTH`, 8: challenge width; signature width is SIG_W = 2^PUF_LENGTH.
- `RUN_CYCLES`, 10: cycles `puf_run` is held high per challenge; minimum 1.
- `SETTLE_CYCLES`, 10: cycles with `puf_run` low before `puf_result` is sampled; minimum 3, to cover the PUF's internal double synchronizer.
- `clk` in 1: single clock, shared with the PUF synchronizers.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a sweep; sampled only in IDLE.
- `golden` in SIG_W: expected signature; must be stable while `busy`.
- `puf_challenge` out PUF_LENGTH: challenge driven to the PUF.
- `puf_run` out 1: PUF run strobe.
- `puf_result` in 1: PUF response, already synchronized.
- `busy` out 1: high from the cycle after `start` is accepted until the cycle before `done`.
- `done` out 1: one-cycle pulse when the sweep completes.
- `signature` out SIG_W: `signature[i]` is the response to challenge i.
- `err_count` out PUF_LENGTH+1: number of bits where the response differs from `golden`; saturates by construction at SIG_W.
- `match` out 1: high when `err_count == 0`; valid while `done` or IDLE after a sweep.

## Operation
- FSM states are IDLE, RUN, SETTLE and DONE.
- IDLE: `puf_run`=0 and `busy`=0. If `start`=1, clear the index, phase counter and `err_count` (leave `signature` as is), then go to RUN.
- RUN: `puf_challenge` = index and `puf_run`=1 for exactly RUN_CYCLES cycles, then go to SETTLE.
- SETTLE: `puf_run`=0 and `puf_challenge` holds. On the clock edge ending the SETTLE_CYCLES-th cycle:
  - capture `puf_result` by right-shifting it in: `signature` <= {puf_result, signature[SIG_W-1:1]};
  - increment `err_count` if `puf_result != golden[index]`;
  - if index == SIG_W-1, go to DONE; otherwise index += 1 and go to RUN.
- DONE: `done`=1 for one cycle, then go to IDLE. `signature`, `err_count` and `match` hold until the next accepted `start`.
- After SIG_W shifts, the challenge-0 result lands in bit 0.
- `start` while busy or in DONE is ignored and is not queued.
- The index is PUF_LENGTH bits and never wraps mid-sweep; the terminal check uses the pre-increment value.
- Reset values: FSM=IDLE; `puf_challenge`=0, `puf_run`=0, `busy`=0, `done`=0, `signature`=0, `err_count`=0; `match`=1 (combinational from `err_count`).
- Reset asserted mid-sweep aborts the sweep on the next edge. All outputs take their reset values, with no `done` pulse.

## Timing
- All outputs are registered, except `match`.
- If `start` is sampled high at edge k in IDLE:
  - RUN occupies cycles k+1 .. k+RUN_CYCLES;
  - SETTLE occupies the next SETTLE_CYCLES cycles;
  - challenge j starts at cycle k+1+j·(RUN_CYCLES+SETTLE_CYCLES).
- `done` is high in cycle k+1+SIG_W·(RUN_CYCLES+SETTLE_CYCLES).
- `puf_challenge` changes only on a SETTLE→RUN transition. It is never changed while `puf_run`=1.
- Back-to-back sweeps are possible: the earliest next accept is the cycle after `done`, since IDLE samples `start`.

## Structure
- Package `puf_pkg` holds:
  - the state enum `seq_state_t` (IDLE, RUN, SETTLE, DONE);
  - default constants `PUF_LENGTH_DEF`=8, `RUN_CYCLES_DEF`=10, `SETTLE_CYCLES_DEF`=10;
  - the function `sig_width(len)` = 1<<len.
- One sub-module, `puf_phase_timer`: a loadable down-counter with a `load`/`expire` interface. It is sized to clog2(max(RUN_CYCLES, SETTLE_CYCLES)+1) bits and is reused for both the RUN and SETTLE phases.
- The FSM, index, signature shift register and mismatch counter all live in the top level.

## Test plan
Common setup: behavioural PUF model returning parity(challenge) after a 2-cycle synchronizer delay; PUF_LENGTH=4, RUN_CYCLES=2, SETTLE_CYCLES=3.
- Golden signature: `golden`=16'h6996, `start` pulse at cycle k -> `signature`=16'h6996, `err_count`=0, `match`=1, `done` exactly at cycle k+81, `busy` high cycles k+1..k+80.
- Single mismatch: `golden`=16'h6997 -> `err_count`=1, `match`=0, `signature` still 16'h6996.
- Handshake and stimulus: `start` held high for the whole sweep -> exactly one sweep, and `start` held high also triggers an immediate second sweep after `done` (checks IDLE sampling). During the sweep, `puf_run` is high 2 cycles and low 3 cycles per challenge, `puf_challenge` steps 0..15 with no change while `puf_run`=1.
- Reset mid-operation: `reset` asserted at challenge 7 in SETTLE -> next cycle FSM=IDLE, all outputs 0, `match`=1, no `done`; a fresh `start` then completes normally with 16'h6996.
- Minimum timing: RUN_CYCLES=1, SETTLE_CYCLES=3, model result=1 for all challenges, `golden`=0 -> `signature`=16'hFFFF, `err_count`=16, `done` at k+65.
